// File: rtl/posit_decode_pipe_if.sv
// Handshake bundle for posit_decode_pipe: producer side (raw posit + tag)
// and consumer side (decoded fields + tag). The master drives inputs and
// accepts results. The slave is the decoder.
interface posit_decode_pipe_if #(
  parameter int N     = 8,
  parameter int ES    = 0,
  parameter int TAG_W = 4
);
  localparam int FW = N - 3 - ES;
  localparam int SW = $clog2(N - 1) + ES + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_posit;
  logic [TAG_W-1:0]     in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic signed [SW-1:0] out_scale;
  logic [FW-1:0]        out_frac;
  logic                 out_zero;
  logic                 out_nar;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_posit, in_tag, out_ready,
    input  in_ready, out_valid, out_sign, out_scale, out_frac,
           out_zero, out_nar, out_tag
  );

  modport slave (
    input  in_valid, in_posit, in_tag, out_ready,
    output in_ready, out_valid, out_sign, out_scale, out_frac,
           out_zero, out_nar, out_tag
  );
endinterface

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: two-stage pipelined posit decoder for any N/ES.
// Stage 1 captures sign, magnitude and the zero/NaR specials; stage 2
// decodes regime, exponent and fraction into a signed scale and an
// MSB-aligned fraction. Full valid/ready back-pressure, one result per cycle.
// Optional feature macro: POSIT_DECODE_STATS_EN adds saturating 16-bit
// zero_count / nar_count outputs counting delivered zero and NaR results.
module posit_decode_pipe #(
  parameter int N     = 8,
  parameter int ES    = 0,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  posit_decode_pipe_if.slave bus
`ifdef POSIT_DECODE_STATS_EN
  ,
  output logic [15:0]        zero_count,
  output logic [15:0]        nar_count
`endif
);

  localparam int FW = N - 3 - ES;
  localparam int SW = $clog2(N - 1) + ES + 1;

  // Stage 1 state
  logic             r_s1Valid;
  logic             r_s1Sign;
  logic [N-2:0]     r_s1Abs;
  logic             r_s1Zero;
  logic             r_s1Nar;
  logic [TAG_W-1:0] r_s1Tag;

  // Stage 2 state (drives the outputs directly)
  logic                 r_s2Valid;
  logic                 r_s2Sign;
  logic signed [SW-1:0] r_s2Scale;
  logic [FW-1:0]        r_s2Frac;
  logic                 r_s2Zero;
  logic                 r_s2Nar;
  logic [TAG_W-1:0]     r_s2Tag;

  // Handshake / load enables
  logic w_s2Load;
  logic w_s1Load;

  // Stage 1 combinational
  logic [N-2:0] w_absLow;
  logic         w_inZero;
  logic         w_inNar;

  // Stage 2 combinational decode
  logic                 w_runBit;
  int                   w_runLen;
  logic                 w_runDone;
  int                   w_k;
  logic [N-2:0]         w_body;
  logic [31:0]          w_bodyWide;
  int                   w_expVal;
  int                   w_scaleInt;
  logic signed [SW-1:0] w_scale;
  logic [FW-1:0]        w_frac;

  // A stage may load when it is empty or its contents move on this cycle;
  // this lets a full pipe keep streaming with no bubbles.
  assign w_s2Load    = !r_s2Valid || bus.out_ready;
  assign w_s1Load    = !r_s1Valid || w_s2Load;
  assign bus.in_ready = w_s1Load;

  // Only the low N-1 bits of |p| matter: for every non-NaR posit the
  // magnitude fits, and NaR is flagged separately.
  assign w_absLow = bus.in_posit[N-1] ? (~bus.in_posit[N-2:0] + (N-1)'(1))
                                      : bus.in_posit[N-2:0];
  assign w_inZero = (bus.in_posit == '0);
  assign w_inNar  = (bus.in_posit == {1'b1, {(N-1){1'b0}}});

  // Stage 1 register: sign, magnitude, special flags and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Sign  <= 1'b0;
      r_s1Abs   <= '0;
      r_s1Zero  <= 1'b0;
      r_s1Nar   <= 1'b0;
      r_s1Tag   <= '0;
    end else if (w_s1Load) begin
      r_s1Valid <= bus.in_valid;
      r_s1Sign  <= bus.in_posit[N-1];
      r_s1Abs   <= w_absLow;
      r_s1Zero  <= w_inZero;
      r_s1Nar   <= w_inNar;
      r_s1Tag   <= bus.in_tag;
    end
  end

  // Measure the regime run: identical bits starting just below the sign.
  always_comb begin
    w_runBit  = r_s1Abs[N-2];
    w_runLen  = 1;
    w_runDone = 1'b0;
    for (int i = N - 3; i >= 0; i--) begin
      if (!w_runDone) begin
        if (r_s1Abs[i] == w_runBit) begin
          w_runLen = w_runLen + 1;
        end else begin
          w_runDone = 1'b1;
        end
      end
    end
  end

  // Turn the run into k, drop regime plus terminator, then peel off the
  // exponent (bits past the end read as zero) and the MSB-aligned fraction.
  always_comb begin
    w_k        = w_runBit ? (w_runLen - 1) : -w_runLen;
    w_body     = r_s1Abs << (w_runLen + 1);
    w_bodyWide = 32'(w_body);
    w_expVal   = int'(w_bodyWide >> (N - 1 - ES));
    w_scaleInt = w_k * (1 << ES) + w_expVal;
    w_scale    = SW'(w_scaleInt);
    w_frac     = w_body[N-2-ES -: FW];
  end

  // Stage 2 register: decoded fields; zero and NaR force scale/frac to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Sign  <= 1'b0;
      r_s2Scale <= '0;
      r_s2Frac  <= '0;
      r_s2Zero  <= 1'b0;
      r_s2Nar   <= 1'b0;
      r_s2Tag   <= '0;
    end else if (w_s2Load) begin
      r_s2Valid <= r_s1Valid;
      r_s2Sign  <= r_s1Sign;
      r_s2Zero  <= r_s1Zero;
      r_s2Nar   <= r_s1Nar;
      r_s2Tag   <= r_s1Tag;
      if (r_s1Zero || r_s1Nar) begin
        r_s2Scale <= '0;
        r_s2Frac  <= '0;
      end else begin
        r_s2Scale <= w_scale;
        r_s2Frac  <= w_frac;
      end
    end
  end

  assign bus.out_valid = r_s2Valid;
  assign bus.out_sign  = r_s2Sign;
  assign bus.out_scale = r_s2Scale;
  assign bus.out_frac  = r_s2Frac;
  assign bus.out_zero  = r_s2Zero;
  assign bus.out_nar   = r_s2Nar;
  assign bus.out_tag   = r_s2Tag;

`ifdef POSIT_DECODE_STATS_EN
  logic        w_outFire;
  logic [15:0] r_zeroCount;
  logic [15:0] r_narCount;

  assign w_outFire = r_s2Valid && bus.out_ready;

  // Count delivered zero / NaR results, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zeroCount <= '0;
      r_narCount  <= '0;
    end else if (w_outFire) begin
      if (r_s2Zero && (r_zeroCount != 16'hFFFF)) begin
        r_zeroCount <= r_zeroCount + 16'd1;
      end
      if (r_s2Nar && (r_narCount != 16'hFFFF)) begin
        r_narCount <= r_narCount + 16'd1;
      end
    end
  end

  assign zero_count = r_zeroCount;
  assign nar_count  = r_narCount;
`endif

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Directed bench for posit_decode_pipe: an N=8/ES=0 instance for the main
// vectors, back-pressure and mid-stream reset, plus an N=16/ES=1 instance
// for the wider scale range.
module tb_posit_decode_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   testCount = 0;
  int   failCount = 0;

  posit_decode_pipe_if #(.N(8),  .ES(0), .TAG_W(4)) busA ();
  posit_decode_pipe_if #(.N(16), .ES(1), .TAG_W(4)) busB ();

`ifdef POSIT_DECODE_STATS_EN
  logic [15:0] zeroCountA, narCountA, zeroCountB, narCountB;
`endif

  posit_decode_pipe #(.N(8), .ES(0), .TAG_W(4)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
`ifdef POSIT_DECODE_STATS_EN
    ,
    .zero_count (zeroCountA),
    .nar_count  (narCountA)
`endif
  );

  posit_decode_pipe #(.N(16), .ES(1), .TAG_W(4)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
`ifdef POSIT_DECODE_STATS_EN
    ,
    .zero_count (zeroCountB),
    .nar_count  (narCountB)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: counts the test and reports on mismatch.
  task automatic checkEq(input string name, input logic [31:0] observed,
                         input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             name, $signed(observed), observed, $signed(expected), expected);
    end
  endtask

  // Present one posit to DUT A (toB=0) or DUT B (toB=1) for exactly one cycle.
  task automatic applyStimulus(input bit toB, input logic [15:0] p,
                               input logic [3:0] t);
    @(negedge clk);
    if (toB) begin
      busB.in_valid = 1'b1;
      busB.in_posit = p;
      busB.in_tag   = t;
    end else begin
      busA.in_valid = 1'b1;
      busA.in_posit = p[7:0];
      busA.in_tag   = t;
    end
    #1;
    checkEq("in_ready_idle", 32'(toB ? busB.in_ready : busA.in_ready), 32'(1));
    @(posedge clk);
    #1;
    busA.in_valid = 1'b0;
    busB.in_valid = 1'b0;
  endtask

  // One cycle after applyStimulus returns, the result must be on DUT A's outputs.
  task automatic checkOutput(input string name, input logic expSign,
                             input int expScale, input logic [4:0] expFrac,
                             input logic expZero, input logic expNar,
                             input logic [3:0] expTag);
    @(posedge clk);
    #1;
    checkEq({name, "_valid"}, 32'(busA.out_valid), 32'(1));
    checkEq({name, "_sign"},  32'(busA.out_sign),  32'(expSign));
    checkEq({name, "_scale"}, 32'(busA.out_scale), 32'(expScale));
    checkEq({name, "_frac"},  32'(busA.out_frac),  32'(expFrac));
    checkEq({name, "_zero"},  32'(busA.out_zero),  32'(expZero));
    checkEq({name, "_nar"},   32'(busA.out_nar),   32'(expNar));
    checkEq({name, "_tag"},   32'(busA.out_tag),   32'(expTag));
  endtask

  // Same latency check for DUT B, comparing the scale only.
  task automatic checkScaleB(input string name, input int expScale);
    @(posedge clk);
    #1;
    checkEq({name, "_valid"}, 32'(busB.out_valid), 32'(1));
    checkEq({name, "_scale"}, 32'(busB.out_scale), 32'(expScale));
  endtask

  logic [7:0] bpPosit [4];
  int         bpScale [4];
  logic [4:0] bpFrac  [4];
  int         sent;
  int         got;
  bit         sawStall;
  bit         inFire;
  bit         outFire;

  initial begin
    rst_n          = 1'b0;
    busA.in_valid  = 1'b0;
    busA.in_posit  = '0;
    busA.in_tag    = '0;
    busA.out_ready = 1'b1;
    busB.in_valid  = 1'b0;
    busB.in_posit  = '0;
    busB.in_tag    = '0;
    busB.out_ready = 1'b1;

    #1;
    checkEq("rst_valid_a", 32'(busA.out_valid), 32'(0));
    checkEq("rst_zero_a",  32'(busA.out_zero),  32'(0));
    checkEq("rst_nar_a",   32'(busA.out_nar),   32'(0));
    checkEq("rst_valid_b", 32'(busB.out_valid), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkEq("rst_in_ready", 32'(busA.in_ready), 32'(1));

    // N=8, ES=0 vectors (fraction is 5 bits)
    applyStimulus(0, 16'h40, 4'd1);
    checkOutput("p40", 1'b0, 0, 5'b00000, 1'b0, 1'b0, 4'd1);
    applyStimulus(0, 16'h50, 4'd2);
    checkOutput("p50", 1'b0, 0, 5'b10000, 1'b0, 1'b0, 4'd2);
    applyStimulus(0, 16'h60, 4'd3);
    checkOutput("p60", 1'b0, 1, 5'b00000, 1'b0, 1'b0, 4'd3);
    applyStimulus(0, 16'hC0, 4'd4);
    checkOutput("pC0", 1'b1, 0, 5'b00000, 1'b0, 1'b0, 4'd4);
    applyStimulus(0, 16'h01, 4'd5);
    checkOutput("p01", 1'b0, -6, 5'b00000, 1'b0, 1'b0, 4'd5);
    applyStimulus(0, 16'h7F, 4'd6);
    checkOutput("p7F", 1'b0, 6, 5'b00000, 1'b0, 1'b0, 4'd6);
    // 0x17 = 0 00 1 0111: regime "00" then terminator gives k=-2, frac 0111
    applyStimulus(0, 16'h17, 4'd7);
    checkOutput("p17", 1'b0, -2, 5'b01110, 1'b0, 1'b0, 4'd7);
    // 0xB0 negates to 0x50
    applyStimulus(0, 16'hB0, 4'd8);
    checkOutput("pB0", 1'b1, 0, 5'b10000, 1'b0, 1'b0, 4'd8);
    applyStimulus(0, 16'h00, 4'd9);
    checkOutput("p00", 1'b0, 0, 5'b00000, 1'b1, 1'b0, 4'd9);
    applyStimulus(0, 16'h80, 4'd10);
    checkOutput("p80", 1'b1, 0, 5'b00000, 1'b0, 1'b1, 4'd10);
    @(posedge clk);
    #1;
`ifdef POSIT_DECODE_STATS_EN
    checkEq("stats_zero", 32'(zeroCountA), 32'(1));
    checkEq("stats_nar",  32'(narCountA),  32'(1));
`endif
    checkEq("drain_valid_a", 32'(busA.out_valid), 32'(0));

    // N=16, ES=1 vectors
    applyStimulus(1, 16'h4000, 4'd1);
    checkScaleB("b4000", 0);
    applyStimulus(1, 16'h6800, 4'd2);
    checkScaleB("b6800", 3);
    applyStimulus(1, 16'h0001, 4'd3);
    checkScaleB("b0001", -28);
    applyStimulus(1, 16'h7FFF, 4'd4);
    checkScaleB("b7FFF", 28);

    // Back-pressure: stream four posits, consumer stalls on cycles 3..6
    bpPosit[0] = 8'h40; bpScale[0] = 0; bpFrac[0] = 5'b00000;
    bpPosit[1] = 8'h50; bpScale[1] = 0; bpFrac[1] = 5'b10000;
    bpPosit[2] = 8'h60; bpScale[2] = 1; bpFrac[2] = 5'b00000;
    bpPosit[3] = 8'h70; bpScale[3] = 2; bpFrac[3] = 5'b00000;
    sent     = 0;
    got      = 0;
    sawStall = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      busA.in_valid  = (sent < 4);
      busA.in_posit  = bpPosit[(sent < 4) ? sent : 0];
      busA.in_tag    = 4'(sent);
      busA.out_ready = !(cyc >= 3 && cyc <= 6);
      #1;
      if (!busA.in_ready) sawStall = 1'b1;
      inFire  = busA.in_valid && busA.in_ready;
      outFire = busA.out_valid && busA.out_ready;
      if (outFire) begin
        checkEq("bp_tag",   32'(busA.out_tag),   32'(got));
        checkEq("bp_scale", 32'(busA.out_scale), 32'(bpScale[got]));
        checkEq("bp_frac",  32'(busA.out_frac),  32'(bpFrac[got]));
        got++;
      end
      @(posedge clk);
      if (inFire) sent++;
    end
    busA.in_valid  = 1'b0;
    busA.out_ready = 1'b1;
    checkEq("bp_count", 32'(got), 32'(4));
    checkEq("bp_stall", 32'(sawStall), 32'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkEq("bp_no_dup", 32'(busA.out_valid), 32'(0));
    end

    // Reset with two results in flight
    @(negedge clk);
    busA.out_ready = 1'b0;
    busA.in_valid  = 1'b1;
    busA.in_posit  = 8'h40;
    busA.in_tag    = 4'd12;
    @(posedge clk);
    #1;
    busA.in_posit  = 8'h50;
    busA.in_tag    = 4'd13;
    @(posedge clk);
    #1;
    busA.in_valid  = 1'b0;
    checkEq("rst_inflight_valid", 32'(busA.out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    checkEq("rst_async_valid", 32'(busA.out_valid), 32'(0));
`ifdef POSIT_DECODE_STATS_EN
    checkEq("rst_stats_zero", 32'(zeroCountA), 32'(0));
`endif
    @(negedge clk);
    rst_n          = 1'b1;
    busA.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkEq("rst_no_stale", 32'(busA.out_valid), 32'(0));
    end
    checkEq("rst_ready_after", 32'(busA.in_ready), 32'(1));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
